mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width; data path fixed at 32 bits.
REQ-002 Parameter REG_ADDR_W, default 5, destination register address width.
REQ-003 Parameter TIMEOUT, default 16, maximum wait cycles for mem_ack_i, range 2..255.
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 wd_i / wreg_i / wdata_i  in  REG_ADDR_W / 1 / 32  register writeback address, enable, data from EX.
REQ-007 whilo_i / hi_i / lo_i  in  1 / 32 / 32  HI/LO write enable and values.
REQ-008 op_i  in  4  access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none.
REQ-009 addr_i / sdata_i  in  ADDR_W / 32  effective address and store source register.
REQ-010 wd_o / wreg_o / wdata_o / whilo_o / hi_o / lo_o  out  as inputs  values to MEM/WB.
REQ-011 stallreq_o  out  1  pipeline stall request.
REQ-012 mem_req_o / mem_we_o / mem_addr_o / mem_sel_o / mem_wdata_o  out  1 / 1 / ADDR_W / 4 / 32  data-bus request.
REQ-013 mem_rdata_i / mem_ack_i  in  32 / 1  read data and completion acknowledge.
REQ-014 align_err_o / bus_err_o  out  1 / 1  one-cycle error flags.

Function
REQ-015 States SHALL be IDLE, BUSY, DONE; TIMEOUT counter SHALL be clog2(TIMEOUT+1) bits.
REQ-016 IDLE, op none: all *_o SHALL equal corresponding *_i combinationally; stallreq_o=0, mem_req_o=0.
REQ-017 Byte lanes big-endian: mem_sel_o = 1000/0100/0010/0001 for addr[1:0]=0..3 (byte), 1100/0011 for addr[1]=0/1 (half), 1111 (word).
REQ-018 mem_addr_o SHALL be addr_i with bits [1:0] forced to 0; mem_we_o=1 for SB/SH/SW only.
REQ-019 mem_wdata_o SHALL replicate sdata_i[7:0] ×4 (SB), sdata_i[15:0] ×2 (SH), sdata_i (SW); 0 for loads.
REQ-020 Misaligned access (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]≠0) in IDLE: no request, align_err_o=1 that cycle, wreg_o=0, whilo_o=0, stallreq_o=0, stay IDLE.
REQ-021 IDLE, aligned memory op: mem_req_o=1 and stallreq_o=1 combinationally; next state DONE if mem_ack_i=1 that cycle, else BUSY.
REQ-022 BUSY: mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o held from inputs (inputs stable during stall); stallreq_o=1; wreg_o=0; whilo_o=0.
REQ-023 BUSY counter SHALL start at 0 on entry and increment each cycle without ack.
REQ-024 mem_ack_i=1 in IDLE-request or BUSY: capture mem_rdata_i into data register, clear error flag, go DONE.
REQ-025 Counter reaching TIMEOUT-1 without ack: drop mem_req_o next cycle, set error flag, go DONE; ack in same cycle as timeout SHALL win (no error).
REQ-026 DONE: mem_req_o=0, stallreq_o=0; next state IDLE unconditionally.
REQ-027 DONE, load, no error: wreg_o=wreg_i, wd_o=wd_i, wdata_o = selected lane of captured data, sign-extended (LB/LH) or zero-extended (LBU/LHU); LW full word.
REQ-028 DONE, store: wreg_o=0; whilo_o/hi_o/lo_o pass through.
REQ-029 DONE with error: bus_err_o=1, wreg_o=0, whilo_o=0.
REQ-030 mem_ack_i outside an outstanding request SHALL be ignored.
REQ-031 align_err_o and bus_err_o SHALL never assert together.

Reset
REQ-032 rst=1 at a clock edge: state←IDLE, counter←0, data register←0, error flag←0.
REQ-033 While rst=1 all outputs SHALL be 0 combinationally, including wd_o, hi_o, lo_o, mem_req_o, stallreq_o.
REQ-034 Reset during BUSY SHALL abandon the transaction; a later stray ack is ignored per REQ-030.

Verification
REQ-035 ALU pass-through: op=0, wd_i=5, wreg_i=1, wdata_i=0x1234, whilo_i=1, hi_i=0xA -> same-cycle identical outputs, stallreq_o=0.
REQ-036 LB addr=0x1001, ack after 3 cycles, rdata=0x11F23344 -> sel=0100, stall 4 cycles, DONE wdata_o=0xFFFFFFF2, wreg_o=1.
REQ-037 SH addr=0x2002, sdata=0xDEADBEEF, zero-wait ack -> sel=0011, wdata=0xBEEFBEEF, we=1, one stall cycle, DONE wreg_o=0.
REQ-038 LW addr=0x3002 -> align_err_o=1 one cycle, mem_req_o=0, wreg_o=0, no stall.
REQ-039 LHU, ack never, TIMEOUT=16 -> req held 16 cycles, then DONE with bus_err_o=1, wreg_o=0, back to IDLE.
REQ-040 LW in BUSY, rst=1 one cycle, then ack pulse -> req drops, state IDLE, ack ignored, outputs 0 during reset.

Source files
------------

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: forwards EX results to MEM/WB, issues aligned
// byte/half/word accesses on a big-endian data bus and stalls until ack/timeout.
module mem_lsu #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           wdata_i,
  input  logic                  whilo_i,
  input  logic [31:0]           hi_i,
  input  logic [31:0]           lo_i,
  input  logic [3:0]            op_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           sdata_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  whilo_o,
  output logic [31:0]           hi_o,
  output logic [31:0]           lo_o,
  output logic                  stallreq_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [3:0]            mem_sel_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  align_err_o,
  output logic                  bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OpLb  = 4'd1;
  localparam logic [3:0] OpLbu = 4'd2;
  localparam logic [3:0] OpLh  = 4'd3;
  localparam logic [3:0] OpLhu = 4'd4;
  localparam logic [3:0] OpLw  = 4'd5;
  localparam logic [3:0] OpSb  = 4'd6;
  localparam logic [3:0] OpSh  = 4'd7;
  localparam logic [3:0] OpSw  = 4'd8;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;

  logic        is_load, is_store, is_mem, is_byte, is_half, is_word, misalign;
  logic [3:0]  sel;
  logic [31:0] store_data;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  // Decode access type, byte lanes and store data replication.
  always_comb begin
    is_load    = (op_i >= OpLb) && (op_i <= OpLw);
    is_store   = (op_i >= OpSb) && (op_i <= OpSw);
    is_mem     = is_load || is_store;
    is_byte    = (op_i == OpLb) || (op_i == OpLbu) || (op_i == OpSb);
    is_half    = (op_i == OpLh) || (op_i == OpLhu) || (op_i == OpSh);
    is_word    = (op_i == OpLw) || (op_i == OpSw);
    misalign   = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    sel        = 4'b0000;
    store_data = 32'h0;
    if (is_byte) begin
      sel = 4'b1000 >> addr_i[1:0];
    end else if (is_half) begin
      sel = addr_i[1] ? 4'b0011 : 4'b1100;
    end else if (is_word) begin
      sel = 4'b1111;
    end
    unique case (op_i)
      OpSb:    store_data = {4{sdata_i[7:0]}};
      OpSh:    store_data = {2{sdata_i[15:0]}};
      OpSw:    store_data = sdata_i;
      default: store_data = 32'h0;
    endcase
  end

  // Pick the addressed lane of the captured word and extend it.
  always_comb begin
    unique case (addr_i[1:0])
      2'd0:    byte_lane = data_q[31:24];
      2'd1:    byte_lane = data_q[23:16];
      2'd2:    byte_lane = data_q[15:8];
      default: byte_lane = data_q[7:0];
    endcase
    half_lane = addr_i[1] ? data_q[15:0] : data_q[31:16];
    unique case (op_i)
      OpLb:    load_data = {{24{byte_lane[7]}}, byte_lane};
      OpLbu:   load_data = {24'h0, byte_lane};
      OpLh:    load_data = {{16{half_lane[15]}}, half_lane};
      OpLhu:   load_data = {16'h0, half_lane};
      OpLw:    load_data = data_q;
      default: load_data = 32'h0;
    endcase
  end

  // State, wait counter, read-data capture and bus-error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state: acks only matter while a request is outstanding; ack beats timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (is_mem && !misalign) begin
          cnt_d = '0;
          if (mem_ack_i) begin
            data_d  = mem_rdata_i;
            err_d   = 1'b0;
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (mem_ack_i) begin
          data_d  = mem_rdata_i;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
          // Counter would reach TIMEOUT-1: give up and flag the bus error.
          cnt_d   = cnt_q + CNT_W'(1);
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: pass-through by default, gated during stalls/errors, all-zero in reset.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = 32'h0;
    whilo_o     = 1'b0;
    hi_o        = 32'h0;
    lo_o        = 32'h0;
    stallreq_o  = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_sel_o   = 4'b0000;
    mem_wdata_o = 32'h0;
    align_err_o = 1'b0;
    bus_err_o   = 1'b0;
    if (!rst) begin
      wd_o    = wd_i;
      wreg_o  = wreg_i;
      wdata_o = wdata_i;
      whilo_o = whilo_i;
      hi_o    = hi_i;
      lo_o    = lo_i;
      unique case (state_q)
        StIdle, StBusy: begin
          if (state_q == StIdle && is_mem && misalign) begin
            align_err_o = 1'b1;
            wreg_o      = 1'b0;
            whilo_o     = 1'b0;
          end else if (state_q == StBusy || is_mem) begin
            stallreq_o  = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = is_store;
            mem_addr_o  = {addr_i[ADDR_W-1:2], 2'b00};
            mem_sel_o   = sel;
            mem_wdata_o = store_data;
            wreg_o      = 1'b0;
            whilo_o     = 1'b0;
          end
        end
        StDone: begin
          if (err_q) begin
            bus_err_o = 1'b1;
            wreg_o    = 1'b0;
            whilo_o   = 1'b0;
          end else if (is_load) begin
            wdata_o = load_data;
          end else if (is_store) begin
            wreg_o = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus queues expected writeback and bus
// records, monitors pop them on non-stalled cycles and on request starts.
module tb_mem_lsu;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        aerr;
    logic        berr;
  } wb_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b1;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        whilo_i;
  logic [31:0] hi_i, lo_i;
  logic [3:0]  op_i;
  logic [31:0] addr_i, sdata_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic        mem_ack_i, align_err_o, bus_err_o;

  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  int   req_cnt = 0;
  logic req_prev = 1'b0;
  wb_t  wb_q[$];
  bus_t bus_q[$];

  mem_lsu #(.ADDR_W(32), .REG_ADDR_W(5), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .whilo_i(whilo_i), .hi_i(hi_i), .lo_i(lo_i),
    .op_i(op_i), .addr_i(addr_i), .sdata_i(sdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o),
    .stallreq_o(stallreq_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic wb_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                             input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                             input logic aerr, input logic berr);
    mk = '{wd: wd, wreg: wreg, wdata: wdata, whilo: whilo, hi: hi, lo: lo,
           aerr: aerr, berr: berr};
  endfunction

  function automatic bus_t mkb(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] wdata);
    mkb = '{we: we, addr: addr, sel: sel, wdata: wdata};
  endfunction

  // Writeback monitor: every non-stalled cycle is one output beat.
  always @(negedge clk) begin
    wb_t e;
    bus_t b;
    if (stallreq_o) stall_cnt++;
    if (mem_req_o) req_cnt++;
    if (!stallreq_o) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = wb_q.pop_front();
        chk("wd_o", 32'(wd_o), 32'(e.wd));
        chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
        chk("wdata_o", wdata_o, e.wdata);
        chk("whilo_o", 32'(whilo_o), 32'(e.whilo));
        chk("hi_o", hi_o, e.hi);
        chk("lo_o", lo_o, e.lo);
        chk("align_err_o", 32'(align_err_o), 32'(e.aerr));
        chk("bus_err_o", 32'(bus_err_o), 32'(e.berr));
      end
    end
    // Bus monitor: compare each request on its first cycle.
    if (mem_req_o && !req_prev) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected_req", 32'd1, 32'd0);
      end else begin
        b = bus_q.pop_front();
        chk("mem_we_o", 32'(mem_we_o), 32'(b.we));
        chk("mem_addr_o", mem_addr_o, b.addr);
        chk("mem_sel_o", 32'(mem_sel_o), 32'(b.sel));
        chk("mem_wdata_o", mem_wdata_o, b.wdata);
      end
    end
    req_prev = mem_req_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic whilo, input logic [31:0] hi, input logic [31:0] lo);
    wd_i = wd; wreg_i = wreg; wdata_i = wdata; whilo_i = whilo; hi_i = hi; lo_i = lo;
  endtask

  // One memory instruction: exp_stall stalled cycles, then the writeback beat.
  task automatic run_mem(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input int ack_at, input logic [31:0] rdata,
                         input int exp_stall, input int exp_req, input logic push_bus,
                         input bus_t eb, input wb_t ed);
    int sbase, rbase;
    op_i = op; addr_i = addr; sdata_i = sdata;
    if (push_bus) bus_q.push_back(eb);
    sbase = stall_cnt;
    rbase = req_cnt;
    for (int i = 0; i <= exp_stall; i++) begin
      mem_ack_i   = (i == ack_at);
      mem_rdata_i = (i == ack_at) ? rdata : 32'hDEAD_DEAD;
      if (i == exp_stall) wb_q.push_back(ed);
      tick();
    end
    mem_ack_i = 1'b0;
    op_i = 4'd0;
    chk({name, "_stall_cycles"}, 32'(stall_cnt - sbase), 32'(exp_stall));
    chk({name, "_req_cycles"}, 32'(req_cnt - rbase), 32'(exp_req));
  endtask

  initial begin
    // Reset with a live aligned LW and ack on the inputs: everything must read 0.
    rst = 1'b1;
    set_wb(5'd3, 1'b1, 32'h9999, 1'b1, 32'h1, 32'h2);
    op_i = 4'd5; addr_i = 32'h100; sdata_i = 32'h0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
    wb_q.push_back('0);
    tick();
    wb_q.push_back('0);
    tick();
    rst = 1'b0; mem_ack_i = 1'b0; op_i = 4'd0;

    // ALU pass-through.
    set_wb(5'd5, 1'b1, 32'h1234, 1'b1, 32'hA, 32'hB);
    wb_q.push_back(mk(5'd5, 1'b1, 32'h1234, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0));
    tick();

    set_wb(5'd7, 1'b1, 32'h55, 1'b0, 32'h11, 32'h22);
    run_mem("lb", 4'd1, 32'h1001, 32'h0, 3, 32'h11F2_3344, 4, 4, 1'b1,
            mkb(1'b0, 32'h1000, 4'b0100, 32'h0),
            mk(5'd7, 1'b1, 32'hFFFF_FFF2, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    run_mem("sh", 4'd7, 32'h2002, 32'hDEAD_BEEF, 0, 32'h0, 1, 1, 1'b1,
            mkb(1'b1, 32'h2000, 4'b0011, 32'hBEEF_BEEF),
            mk(5'd7, 1'b0, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));

    set_wb(5'd9, 1'b1, 32'h77, 1'b1, 32'h33, 32'h44);
    run_mem("lw_misalign", 4'd5, 32'h3002, 32'h0, -1, 32'h0, 0, 0, 1'b0, '0,
            mk(5'd9, 1'b0, 32'h77, 1'b0, 32'h33, 32'h44, 1'b1, 1'b0));

    set_wb(5'd7, 1'b1, 32'h55, 1'b1, 32'h11, 32'h22);
    run_mem("lhu_timeout", 4'd4, 32'h4000, 32'h0, -1, 32'h0, 16, 16, 1'b1,
            mkb(1'b0, 32'h4000, 4'b1100, 32'h0),
            mk(5'd7, 1'b0, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b1));
    wb_q.push_back(mk(5'd7, 1'b1, 32'h55, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0));
    tick();

    set_wb(5'd7, 1'b1, 32'h55, 1'b0, 32'h11, 32'h22);
    run_mem("lbu", 4'd2, 32'h5003, 32'h0, 1, 32'h0000_0080, 2, 2, 1'b1,
            mkb(1'b0, 32'h5000, 4'b0001, 32'h0),
            mk(5'd7, 1'b1, 32'h0000_0080, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    run_mem("lh", 4'd3, 32'h6000, 32'h0, 0, 32'h8001_1234, 1, 1, 1'b1,
            mkb(1'b0, 32'h6000, 4'b1100, 32'h0),
            mk(5'd7, 1'b1, 32'hFFFF_8001, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    run_mem("sw", 4'd8, 32'h7004, 32'hCAFE_F00D, 0, 32'h0, 1, 1, 1'b1,
            mkb(1'b1, 32'h7004, 4'b1111, 32'hCAFE_F00D),
            mk(5'd7, 1'b0, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    run_mem("sb", 4'd6, 32'h7005, 32'h1234_5678, 2, 32'h0, 3, 3, 1'b1,
            mkb(1'b1, 32'h7004, 4'b0100, 32'h7878_7878),
            mk(5'd7, 1'b0, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    // Ack on the final permitted cycle wins over the timeout.
    run_mem("lw_late_ack", 4'd5, 32'h8000, 32'h0, 15, 32'h0102_0304, 16, 16, 1'b1,
            mkb(1'b0, 32'h8000, 4'b1111, 32'h0),
            mk(5'd7, 1'b1, 32'h0102_0304, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));

    // Stray ack while idle is ignored.
    mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_AAAA;
    wb_q.push_back(mk(5'd7, 1'b1, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    tick();
    mem_ack_i = 1'b0;

    // Reset while BUSY abandons the access; the late ack is ignored.
    op_i = 4'd5; addr_i = 32'h9000;
    bus_q.push_back(mkb(1'b0, 32'h9000, 4'b1111, 32'h0));
    tick();
    tick();
    rst = 1'b1;
    wb_q.push_back('0);
    tick();
    chk("rst_req_low", 32'(req_prev), 32'd0);
    rst = 1'b0; op_i = 4'd0; mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    wb_q.push_back(mk(5'd7, 1'b1, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    tick();
    mem_ack_i = 1'b0;
    wb_q.push_back(mk(5'd7, 1'b1, 32'h55, 1'b0, 32'h11, 32'h22, 1'b0, 1'b0));
    tick();

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
